tcdm_bank_responder: RTL

- Target-side endpoint of the TCDM request/grant protocol. Tile masters drive this protocol through the local crossbar and the butterfly interconnect.
- Sits between one interconnect output port and one SRAM bank.
- Accepts req/gnt transactions, drives the bank with fixed read latency, and returns responses as vld/rdata with network backpressure.
- Credit-based granting guarantees no response is ever dropped.

---
 rtl/mempool_pkg.sv | 9 +
 rtl/fifo_v3.sv | 52 +++++
 rtl/tcdm_bank_responder.sv | 79 +++++++
 3 files changed

// File: rtl/mempool_pkg.sv
// mempool_pkg: shared TCDM widths and types for the bank endpoint
package mempool_pkg;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned TCDMAddrMemWidth = 10;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0] be_t;
  typedef logic [TCDMAddrMemWidth-1:0] tcdm_addr_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: circular FIFO whose fall-through mode exposes a push into an empty FIFO in the same cycle
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned CntW = ADDR_DEPTH + 1;
  localparam logic [ADDR_DEPTH-1:0] Last = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic bypass, skip, do_push, do_pop;
  always_comb begin
    bypass = FALL_THROUGH && cnt_q == '0 && push_i;
    skip = bypass && pop_i;
    full_o = cnt_q == FullCnt;
    empty_o = cnt_q == '0 && !bypass;
    data_o = bypass ? data_i : mem_q[rd_q];
    do_push = push_i && !full_o && !skip;
    do_pop = pop_i && !empty_o && !skip;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = data_i;
    wr_d = do_push ? (wr_q == Last ? '0 : wr_q + ADDR_DEPTH'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == Last ? '0 : rd_q + ADDR_DEPTH'(1)) : rd_q;
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: TCDM target endpoint that grants against response credits, drives one SRAM bank and buffers in-order responses
module tcdm_bank_responder
  import mempool_pkg::*;
#(
  parameter int unsigned MemLatency  = 1,
  parameter int unsigned RespDepth   = 2,
  parameter bit          WriteRespOn = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [TCDMAddrMemWidth-1:0] addr_i,
  input  logic                        wen_i,
  input  logic [DataWidth-1:0]        wdata_i,
  input  logic [BeWidth-1:0]          be_i,
  output logic                        vld_o,
  output logic [DataWidth-1:0]        rdata_o,
  input  logic                        rready_i,
  output logic                        mem_req_o,
  output logic [TCDMAddrMemWidth-1:0] mem_addr_o,
  output logic                        mem_wen_o,
  output logic [DataWidth-1:0]        mem_wdata_o,
  output logic [BeWidth-1:0]          mem_be_o,
  input  logic [DataWidth-1:0]        mem_rdata_i
);
  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam logic [CW-1:0] MaxCred = CW'(RespDepth);
  logic resp_req, ins, push, pop, full, empty;
  logic [CW-1:0] credits_q, credits_d;
  logic [MemLatency-1:0] pv_q, pv_d, pw_q, pw_d;
  data_t push_data;
  always_comb begin
    resp_req = ~wen_i | WriteRespOn;
    gnt_o = req_i & ~rst_i & (~resp_req | (credits_q < MaxCred));
    ins = gnt_o & resp_req;
    mem_req_o = gnt_o;
    mem_addr_o = addr_i;
    mem_wen_o = wen_i;
    mem_wdata_o = wdata_i;
    mem_be_o = be_i;
    push = pv_q[MemLatency-1];
    push_data = pw_q[MemLatency-1] ? '0 : mem_rdata_i;
    vld_o = ~empty;
    pop = vld_o & rready_i;
    pv_d = MemLatency'({pv_q, ins});
    pw_d = MemLatency'({pw_q, wen_i});
    credits_d = credits_q + CW'(ins) - CW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pw_q <= '0;
      credits_q <= '0;
    end else begin
      pv_q <= pv_d;
      pw_q <= pw_d;
      credits_q <= credits_d;
    end
  end
  fifo_v3 #(
    .FALL_THROUGH(1'b1),
    .DATA_WIDTH  (DataWidth),
    .DEPTH       (RespDepth)
  ) i_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .flush_i(rst_i),
    .full_o (full),
    .empty_o(empty),
    .data_i (push_data),
    .push_i (push),
    .data_o (rdata_o),
    .pop_i  (pop)
  );
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  assert property (@(posedge clk_i) disable iff (rst_i) !(pop && credits_q == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) credits_q <= MaxCred);
endmodule
